// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared FSM states, Booth triplet codes and step-count helper for booth_mul_r4
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Triplets {q[2i+1], q[2i], q[2i-1]} that need special handling in the recoder
    localparam logic [2:0] TRIP_P2 = 3'b011;
    localparam logic [2:0] TRIP_M2 = 3'b100;
    localparam logic [2:0] TRIP_Z1 = 3'b111;

    function automatic int booth_iter(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// rtl/booth_r4_enc.sv - radix-4 Booth recoder: triplet to sign/magnitude select
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0] triplet,
    output logic       neg,
    output logic       one,
    output logic       two
);

    // 111 is digit 0, so it must not request a negation
    assign neg = triplet[2] && (triplet != TRIP_Z1);
    assign one = triplet[1] ^ triplet[0];
    assign two = (triplet == TRIP_P2) || (triplet == TRIP_M2);

endmodule

// File: rtl/booth_mul_r4.sv
// rtl/booth_mul_r4.sv - iterative radix-4 Booth multiplier; optional BOOTH_EARLY_TERM_EN ends EXEC once remaining digits are all zero
module booth_mul_r4
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result,
    output logic [1:0]           cur_state,
    output logic                 busy
);

    localparam int ITER = booth_iter(WIDTH);
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 2;
    localparam int CW   = $clog2(ITER);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_mul_r4: WIDTH must be even and >= 4");
    end

    state_t              state_q, state_d;
    logic [EW-1:0]       mplier_q;
    logic                q_m1;
    logic [AW-1:0]       mcand_q;
    logic [AW-1:0]       acc_q;
    logic [CW-1:0]       cnt_q;
    logic [2*WIDTH-1:0]  result_q;

    logic                neg, one, two;
    logic [AW-1:0]       pp_mag, pp, acc_next;
    logic                last_step;
    logic                sa, sb;

    booth_r4_enc u_enc (
        .triplet ({mplier_q[1:0], q_m1}),
        .neg     (neg),
        .one     (one),
        .two     (two)
    );

    // The multiplicand register is pre-shifted by 2 each step, so no variable shifter is needed
    assign pp_mag   = two ? {mcand_q[AW-2:0], 1'b0} : (one ? mcand_q : '0);
    assign pp       = neg ? -pp_mag : pp_mag;
    assign acc_next = acc_q + pp;

    assign sa = signed_mode & multiplicand[WIDTH-1];
    assign sb = signed_mode & multiplier[WIDTH-1];

`ifdef BOOTH_EARLY_TERM_EN
    // mplier_q[EW-1:1] is everything left after this step, with q[2i+1] becoming the next q[-1]
    assign last_step = (cnt_q == CW'(ITER - 1)) || (&mplier_q[EW-1:1]) || !(|mplier_q[EW-1:1]);
`else
    assign last_step = (cnt_q == CW'(ITER - 1));
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op_start) state_d = EXEC;
            EXEC:    if (last_step) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (op_clear) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mplier_q <= '0;
            q_m1     <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (op_clear) begin
            result_q <= '0;
        end else if (state_q == IDLE && op_start) begin
            mplier_q <= {{2{sb}}, multiplier};
            mcand_q  <= {{(AW-WIDTH){sa}}, multiplicand};
            q_m1     <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == EXEC) begin
            acc_q    <= acc_next;
            mplier_q <= {{2{mplier_q[EW-1]}}, mplier_q[EW-1:2]};
            q_m1     <= mplier_q[1];
            mcand_q  <= {mcand_q[AW-3:0], 2'b00};
            cnt_q    <= cnt_q + 1'b1;
            if (last_step) result_q <= acc_next[2*WIDTH-1:0];
        end
    end

    assign op_done   = (state_q == DONE);
    assign busy      = (state_q == EXEC);
    assign cur_state = state_q;
    assign result    = result_q;

endmodule

// File: tb/tb_booth_mul_r4.sv
// tb/tb_booth_mul_r4.sv - directed vector table and handshake sequences for booth_mul_r4 (WIDTH 32 and 8)
module tb_booth_mul_r4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_start = 1'b0, op_clear = 1'b0, signed_mode = 1'b0;
    logic [31:0] multiplier = '0, multiplicand = '0;
    logic        op_done, busy;
    logic [63:0] result;
    logic [1:0]  cur_state;

    logic        start8 = 1'b0, clear8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        done8, busy8;
    logic [15:0] result8;
    logic [1:0]  state8;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    booth_mul_r4 #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
        .signed_mode(signed_mode), .multiplier(multiplier), .multiplicand(multiplicand),
        .op_done(op_done), .result(result), .cur_state(cur_state), .busy(busy)
    );

    booth_mul_r4 #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .op_start(start8), .op_clear(clear8),
        .signed_mode(sm8), .multiplier(b8), .multiplicand(a8),
        .op_done(done8), .result(result8), .cur_state(state8), .busy(busy8)
    );

    typedef struct {
        logic        sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Operands are scrambled right after the start edge to show they are not re-sampled
    task automatic run32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int cycles, output int busy_cycles,
                         output bit zero_ok);
        signed_mode  = sm;
        multiplicand = a;
        multiplier   = b;
        op_start     = 1'b1;
        step();
        op_start     = 1'b0;
        multiplicand = ~a;
        multiplier   = 32'h1234_5678;
        signed_mode  = ~sm;
        cycles       = 0;
        busy_cycles  = busy ? 1 : 0;
        zero_ok      = (result == 64'd0);
        while (!op_done && cycles < 100) begin
            step();
            cycles++;
            if (busy) begin
                busy_cycles++;
                if (result != 64'd0) zero_ok = 1'b0;
            end
        end
        res = result;
    endtask

    task automatic clear32();
        op_clear = 1'b1;
        step();
        op_clear = 1'b0;
    endtask

    initial begin
        logic [63:0] res;
        int          cycles, bcyc;
        bit          zok;

        vecs[0] = '{1'b1, 32'd7,          32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFCF};
        vecs[1] = '{1'b0, 32'd7,          32'hFFFF_FFF9, 64'h0000_0006_FFFF_FFCF};
        vecs[2] = '{1'b1, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[4] = '{1'b1, 32'd3,          32'd5,         64'd15};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        vecs[6] = '{1'b0, 32'd0,          32'h0000_1234, 64'd0};
        vecs[7] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'd1};

        reset_n = 1'b0;
        step();
        chk("reset_state",  {62'd0, cur_state}, 64'd0);
        chk("reset_done",   {63'd0, op_done},   64'd0);
        chk("reset_busy",   {63'd0, busy},      64'd0);
        chk("reset_result", result,             64'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run32(vecs[i].sm, vecs[i].a, vecs[i].b, res, cycles, bcyc, zok);
            chk($sformatf("vec%0d_done", i), {63'd0, op_done}, 64'd1);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_zero_in_exec", i), {63'd0, zok}, 64'd1);
`ifndef BOOTH_EARLY_TERM_EN
            chk($sformatf("vec%0d_latency", i), 64'(cycles), 64'd17);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(bcyc), 64'd17);
`endif
            clear32();
            chk($sformatf("vec%0d_clr_state", i), {62'd0, cur_state}, 64'd0);
            chk($sformatf("vec%0d_clr_result", i), result, 64'd0);
        end

        // Abort with op_clear five edges into EXEC
        signed_mode = 1'b1; multiplicand = 32'd9; multiplier = 32'h5555_5555; op_start = 1'b1;
        step();
        op_start = 1'b0;
        repeat (4) step();
        chk("abort_still_busy", {63'd0, busy}, 64'd1);
        op_clear = 1'b1;
        step();
        op_clear = 1'b0;
        chk("abort_state",  {62'd0, cur_state}, 64'd0);
        chk("abort_done",   {63'd0, op_done},   64'd0);
        chk("abort_result", result,             64'd0);

        // Asynchronous reset in the middle of EXEC
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        repeat (3) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_state", {62'd0, cur_state}, 64'd0);
        chk("areset_busy",  {63'd0, busy},      64'd0);
        chk("areset_done",  {63'd0, op_done},   64'd0);
        reset_n = 1'b1;
        step();
        chk("areset_stays_idle", {62'd0, cur_state}, 64'd0);

        // op_start held high through DONE must not restart the operation
        signed_mode = 1'b1; multiplicand = 32'd3; multiplier = 32'd5; op_start = 1'b1;
        step();
        cycles = 0;
        while (!op_done && cycles < 100) begin
            step();
            cycles++;
        end
        chk("held_done", {63'd0, op_done}, 64'd1);
        repeat (4) step();
        chk("held_state",  {62'd0, cur_state}, 64'd2);
        chk("held_result", result,             64'd15);
        op_clear = 1'b1;
        step();
        op_clear = 1'b0;
        op_start = 1'b0;
        chk("held_clr_state", {62'd0, cur_state}, 64'd0);
        run32(1'b1, 32'd3, 32'd5, res, cycles, bcyc, zok);
        chk("restart_result", res, 64'd15);
        clear32();

        // Clear beats start in IDLE
        op_start = 1'b1; op_clear = 1'b1;
        step();
        chk("clr_start_state", {62'd0, cur_state}, 64'd0);
        chk("clr_start_busy",  {63'd0, busy},      64'd0);
        op_start = 1'b0; op_clear = 1'b0;
        step();
        chk("clr_start_idle_after", {62'd0, cur_state}, 64'd0);

`ifdef BOOTH_EARLY_TERM_EN
        run32(1'b1, 32'd12345, 32'd2, res, cycles, bcyc, zok);
        chk("early_result", res, 64'd24690);
        chk("early_fast", {63'd0, (cycles >= 1 && cycles <= 2)}, 64'd1);
        clear32();
`endif

        // WIDTH=8 random pairs against a locally computed product
        for (int n = 0; n < 200; n++) begin
            logic [7:0]  ra, rb;
            logic [15:0] expv, ea, eb;
            int          c8;
            ra = 8'($urandom);
            rb = 8'($urandom);
            sm8 = n[0];
            ea = sm8 ? {{8{ra[7]}}, ra} : {8'd0, ra};
            eb = sm8 ? {{8{rb[7]}}, rb} : {8'd0, rb};
            expv = ea * eb;
            a8 = ra; b8 = rb; start8 = 1'b1;
            step();
            start8 = 1'b0;
            c8 = 0;
            while (!done8 && c8 < 50) begin
                step();
                c8++;
            end
            chk($sformatf("w8_%0d_a%h_b%h_s%0d", n, ra, rb, sm8), {48'd0, result8}, {48'd0, expv});
            clear8 = 1'b1;
            step();
            clear8 = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mul_r4.md
Name: booth_mul_r4

Overview:
- Parametrised, iterative radix-4 Booth multiplier. Successor to the fixed 32-bit radix-2 `mul` block.
- Adds generic operand width, a runtime signed/unsigned mode and two product bits retired per cycle.
- Sits on the same op_start/op_clear/op_done handshake as `mul`, so existing controllers and benches drive it unchanged.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and >= 4; an elaboration check fails otherwise.
- ITER, WIDTH/2+1, number of Booth steps (derived localparam, not user-overridable).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- op_start  input  1  start request, sampled only in IDLE.
- op_clear  input  1  synchronous clear/abort, returns the block to IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned. Sampled with op_start.
- multiplier  input  WIDTH  operand B, sampled with op_start.
- multiplicand  input  WIDTH  operand A, sampled with op_start.
- op_done  output  1  high while the result is valid (DONE state).
- result  output  2*WIDTH  product.
- cur_state  output  2  encoded FSM state for debug.
- busy  output  1  high in EXEC.

Behaviour:
- **Reset (async, reset_n=0):**
  - state=IDLE, op_done=0, busy=0, result=0, cur_state=2'b00.
  - All internal registers are cleared. Reset mid-operation discards the operation immediately.
- **States:** IDLE=00, EXEC=01, DONE=10; 11 is unused and recovers to IDLE on the next edge.
- **IDLE:**
  - Moves to EXEC when op_start=1 and op_clear=0.
  - On that edge, both operands are extended by 2 bits (sign-extended if signed_mode=1, zero-extended if 0) and latched. The accumulator is cleared, the step counter is set to 0 and the implicit Booth bit q[-1] is set to 0.
- **EXEC, one step per edge:**
  - Recode the multiplier triplet {q[2i+1], q[2i], q[2i-1]} to a digit in {-2,-1,0,+1,+2}.
  - Add the digit times the extended multiplicand, shifted left by 2i, into a 2*WIDTH+2-bit accumulator.
  - After ITER steps, move to DONE. result = accumulator[2*WIDTH-1:0].
- **Latency:** with op_start sampled at edge k, op_done rises after edge k+ITER (17 edges for WIDTH=32). Latency is fixed unless the optional feature is enabled.
- **DONE:**
  - op_done=1 and result holds until op_clear=1.
  - op_start is ignored in DONE; back-to-back operations require an op_clear first.
- **op_clear:**
  - Highest synchronous priority in every state: next state IDLE, result=0, op_done=0.
  - If op_clear and op_start are high in the same IDLE cycle, clear wins and no operation starts.
- **Mid-operation rules:**
  - op_start and operand changes during EXEC or DONE have no effect.
  - result is not updated during EXEC; it shows 0 or the previous value until DONE is entered.
- **Width rule:** arithmetic is exact modulo 2^(2*WIDTH) for all operand pairs in both modes, including the most-negative operand and all-ones unsigned operands.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- **Defined:** the block terminates early in EXEC when the remaining unprocessed extended multiplier bits, including the current q[-1], are all equal. All remaining digits are then 0, so the FSM goes to DONE on that edge with the accumulator as the final value. Results are identical to the non-terminating case; latency varies between 1 and ITER edges.
- **Undefined:** the comparison logic is absent and latency is fixed at ITER.

Decomposition:
- Package booth_pkg holds:
  - the state enum/localparams (IDLE, EXEC, DONE);
  - the Booth digit encoding constants;
  - a function computing ITER from WIDTH.
- Sub-module booth_r4_enc: combinational recoder. Triplet in; outputs neg, one, two. The top level builds the partial product from these and handles the counter, FSM and accumulator.

Test Plan:
- WIDTH=32, signed_mode=1, A=7, B=32'hFFFF_FFF9, pulse op_start → op_done after exactly 17 edges, result=64'hFFFF_FFFF_FFFF_FFCF, busy high for 17 cycles.
- Same operands with signed_mode=0 → result=64'h0000_0006_FFFF_FFCF.
- Boundary operands:
  - signed_mode=1, A=B=32'h8000_0000 → result=64'h4000_0000_0000_0000.
  - signed_mode=0, A=B=32'hFFFF_FFFF → result=64'hFFFF_FFFE_0000_0001.
- Interrupt cases:
  - op_clear asserted 5 edges into EXEC → next cycle state IDLE, op_done=0, result=0.
  - reset_n pulsed low mid-EXEC → outputs cleared asynchronously, before the next clock edge.
- Handshake ordering:
  - op_start held high through DONE → no restart; result stable.
  - op_clear then op_start with A=3, B=5 → result=15.
  - op_clear and op_start high together in IDLE → stays IDLE.
- Parameter and feature coverage:
  - WIDTH=8, 200 random signed and unsigned pairs checked against the reference product. With BOOTH_EARLY_TERM_EN, the same results are required.
  - With BOOTH_EARLY_TERM_EN, WIDTH=32 signed, B=2 → op_done within 2 edges.
